// File: rtl/booth_multiplier.sv
// Sequential 16x16 signed radix-2 Booth multiplier.
// Operands arrive serially on data_in (multiplicand, then multiplier).
// A 17-bit accumulator performs 16 add/subtract-and-shift iterations.
// The accumulator is one bit wider than the operands so that -32768 * -32768 is exact.
module booth_multiplier (
   input  logic [15:0] data_in,
   input  logic        clk,
   input  logic        start,
   output logic [31:0] result,
   input  logic        rst,
   output logic        done
);

   localparam int unsigned OP_W   = 16;
   localparam int unsigned ACC_W  = OP_W + 1;
   localparam int unsigned PROD_W = 2 * OP_W;
   localparam int unsigned CNT_W  = 5;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_M,
      LOAD_Q,
      CALC,
      DONE
   } state_t;

   state_t             state;
   state_t             next_state;

   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   mcand;
   logic [OP_W-1:0]    mplier;
   logic               q_1;
   logic [CNT_W-1:0]   count;

   logic [ACC_W-1:0]   acc_sum;
   logic [ACC_W-1:0]   acc_shift;
   logic [OP_W-1:0]    mplier_shift;
   logic               last_iter;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic; the 16th iteration is the CALC cycle where count is 1
   always_comb begin
      next_state = state;
      last_iter  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               next_state = LOAD_M;
            end
         end
         LOAD_M: next_state = LOAD_Q;
         LOAD_Q: next_state = CALC;
         CALC: begin
            if (count == CNT_W'(1)) begin
               last_iter  = 1'b1;
               next_state = DONE;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Booth step: add/subtract the multiplicand, then arithmetic-shift {A,Q,q_1} right by one
   always_comb begin
      acc_sum = acc;
      case ({mplier[0], q_1})
         2'b01:   acc_sum = acc + mcand;
         2'b10:   acc_sum = acc - mcand;
         default: acc_sum = acc;
      endcase
      acc_shift    = {acc_sum[ACC_W-1], acc_sum[ACC_W-1:1]};
      mplier_shift = {acc_sum[0], mplier[OP_W-1:1]};
   end

   // Datapath registers: operand capture, iteration state and counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         q_1    <= 1'b0;
         count  <= '0;
      end else begin
         case (state)
            LOAD_M: begin
               mcand <= {data_in[OP_W-1], data_in};
            end
            LOAD_Q: begin
               mplier <= data_in;
               acc    <= '0;
               q_1    <= 1'b0;
               count  <= CNT_W'(OP_W);
            end
            CALC: begin
               acc    <= acc_shift;
               mplier <= mplier_shift;
               q_1    <= mplier[0];
               count  <= count - CNT_W'(1);
            end
            default: begin
               acc <= acc;
            end
         endcase
      end
   end

   // Product register (updated only on the completing iteration) and registered done flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         result <= '0;
         done   <= 1'b0;
      end else begin
         done <= (next_state == DONE);
         if (last_iter) begin
            result <= PROD_W'({acc_shift[OP_W-1:0], mplier_shift});
         end
      end
   end

endmodule

// File: tb/tb_booth_multiplier.sv
// Scoreboard bench for booth_multiplier: the driver pushes the expected product and completion cycle,
// and a negedge monitor pops and compares them whenever done is seen.
`timescale 1ns/1ps
module tb_booth_multiplier;

   logic [15:0] data_in;
   logic        clk;
   logic        start;
   logic [31:0] result;
   logic        rst;
   logic        done;

   typedef struct {
      logic [31:0] val;
      int          cyc;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   cyc   = 0;
   logic prev_done = 1'b0;

   booth_multiplier dut (
      .data_in (data_in),
      .clk     (clk),
      .start   (start),
      .result  (result),
      .rst     (rst),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
      end
   endtask

   // Monitor: pop the expected product whenever done is presented
   always @(negedge clk) begin
      if (!rst) begin
         if (done) begin
            check("done_single_cycle", 32'(prev_done), 32'd0);
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL spurious_done: got done=1 at cycle %0d expected no pending operation", cyc);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check({e.name, "_result"}, result, e.val);
               check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
         end
         prev_done = done;
      end else begin
         prev_done = 1'b0;
      end
   end

   // Issue one multiply; the caller is at a negedge with the FSM in IDLE or DONE.
   // Returns at the negedge after the DONE->IDLE edge, with start = hold.
   task automatic run_op(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] expv, input bit hold);
      exp_t e;
      start   = 1'b1;
      data_in = 16'($urandom);
      @(posedge clk); @(negedge clk);
      data_in = a;
      start   = hold;
      @(posedge clk); @(negedge clk);
      data_in = b;
      @(posedge clk); @(negedge clk);
      e.val  = expv;
      e.cyc  = cyc + 16;
      e.name = name;
      exp_q.push_back(e);
      for (int i = 0; i < 17; i++) begin
         data_in = 16'($urandom);
         start   = 1'(($urandom) & 1);
         @(negedge clk);
      end
      start = hold;
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      data_in = 16'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_result", result, 32'h0);
      check("reset_done", 32'(done), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      run_op("basic_10x13", 16'd10, 16'd13, 32'd130, 1'b0);
      repeat (4) @(negedge clk);

      run_op("b2b_4x5", 16'd4, 16'd5, 32'd20, 1'b1);
      run_op("b2b_320x140", 16'd320, 16'd140, 32'd44800, 1'b1);
      run_op("b2b_720x30007", 16'd720, 16'd30007, 32'd21605040, 1'b0);
      repeat (3) @(negedge clk);

      run_op("neg3x7", 16'hFFFD, 16'd7, 32'hFFFF_FFEB, 1'b0);
      run_op("7xneg3", 16'd7, 16'hFFFD, 32'hFFFF_FFEB, 1'b0);
      run_op("neg1xneg1", 16'hFFFF, 16'hFFFF, 32'h0000_0001, 1'b0);
      run_op("min_x_min", 16'h8000, 16'h8000, 32'h4000_0000, 1'b0);
      run_op("max_x_min", 16'h7FFF, 16'h8000, 32'hC000_8000, 1'b0);
      run_op("min_x_max", 16'h8000, 16'h7FFF, 32'hC000_8000, 1'b0);
      run_op("zero_x_val", 16'h0000, 16'd12345, 32'h0, 1'b0);
      run_op("val_x_zero", 16'hABCD, 16'h0000, 32'h0, 1'b0);
      repeat (2) @(negedge clk);

      // Abort (1200,140) at iteration 8 with reset
      start   = 1'b1;
      @(posedge clk); @(negedge clk);
      data_in = 16'd1200;
      start   = 1'b0;
      @(posedge clk); @(negedge clk);
      data_in = 16'd140;
      @(posedge clk);
      repeat (8) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("abort_result", result, 32'h0);
      check("abort_done", 32'(done), 32'h0);
      rst = 1'b0;
      repeat (25) @(negedge clk);
      check("abort_result_held", result, 32'h0);

      run_op("after_abort_1200x140", 16'd1200, 16'd140, 32'd168000, 1'b0);

      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
      check("pending_ops", 32'(exp_q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
